// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit
//   Instruction-fetch initiator for the instruction memory's combinational read
//   port. It keeps the PC, reads one word per cycle and hands {instr, pc} to
//   decode over a valid/ready handshake. It also handles redirect flushes,
//   decode back-pressure and misaligned-target faults.
//
//   Optional feature macro: FETCH_BUF_EN
//     defined   -> 2-entry output FIFO, so a single decode stall costs no bubble
//     undefined -> single output register (depth 1)
//
//   Buffer organisation: slot0 is always the head entry and drives
//   out_instr/out_pc directly. Because of that, the outputs keep their last
//   value whenever the buffer is empty or has been flushed. slot1 exists only
//   in the buffered build and holds the second entry.

module imem_fetch_unit #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] RESET_PC = ADDRWIDTH'(32'h01000000)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_instr,
  output logic [ADDRWIDTH-1:0] out_pc,
  output logic                 fault,
  output logic [ADDRWIDTH-1:0] fault_pc,
  output logic [ADDRWIDTH-1:0] imem_address,
  output logic                 imem_read_write,
  output logic [DATAWIDTH-1:0] imem_data_in,
  input  logic [DATAWIDTH-1:0] imem_data_out
);

  // Buffer depth depends on the build option. The occupancy counter is wide
  // enough for the two-entry case.
`ifdef FETCH_BUF_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  localparam logic [DATAWIDTH-1:0] NOP_INSTR = DATAWIDTH'(32'h00000013);
  localparam logic [ADDRWIDTH-1:0] PC_STEP   = ADDRWIDTH'(4);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  fetch_state_t         state;
  fetch_state_t         state_next;

  logic [ADDRWIDTH-1:0] pc;
  logic [1:0]           count;
  logic [1:0]           count_next;

  logic [DATAWIDTH-1:0] slot0_instr;
  logic [ADDRWIDTH-1:0] slot0_pc;
`ifdef FETCH_BUF_EN
  logic [DATAWIDTH-1:0] slot1_instr;
  logic [ADDRWIDTH-1:0] slot1_pc;
`endif

  logic                 pop;
  logic                 push;
  logic                 room;
  logic                 target_aligned;

  // The memory port is read-only and is addressed straight from the PC register.
  assign imem_address    = pc;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = '0;

  // The head slot drives decode. Valid means the buffer holds at least one entry.
  assign out_valid = (count != 2'd0);
  assign out_instr = slot0_instr;
  assign out_pc    = slot0_pc;

  assign target_aligned = (redirect_target[1:0] == 2'b00);

  // This register holds the FSM state. Reset returns it to RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // This block computes the next state, the handshake decisions and the next occupancy.
  // A redirect overrides everything: it flushes the buffer and voids any
  // pop on the same edge. In FAULT the buffer is already empty and nothing is pushed.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    push       = 1'b0;
    room       = 1'b0;
    count_next = count;

    if (redirect_valid) begin
      count_next = 2'd0;
      state_next = target_aligned ? RUN : FAULT;
    end else begin
      pop        = out_valid & out_ready;
      room       = (count < DEPTH) | pop;
      push       = (state == RUN) & fetch_en & room;
      count_next = count + 2'(push) - 2'(pop);
    end
  end

  // This block updates the PC and the fault record.
  // An aligned redirect loads the target and clears the fault. A misaligned
  // redirect records the target and leaves the PC unchanged. Otherwise the PC
  // advances by one word on each push and wraps naturally at the top of the address space.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      if (target_aligned) begin
        pc    <= redirect_target;
        fault <= 1'b0;
      end else begin
        fault    <= 1'b1;
        fault_pc <= redirect_target;
      end
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // This block tracks buffer occupancy. A flush only zeroes the count.
  // The slot contents stay put, so the outputs hold their last values.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      count <= count_next;
    end
  end

`ifdef FETCH_BUF_EN
  // This block updates the two-entry FIFO slots.
  // A new word lands in slot0 when the head position becomes free on this
  // edge. Otherwise it lands in slot1. A pop from a full buffer moves slot1 up into slot0.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot0_instr <= NOP_INSTR;
      slot0_pc    <= '0;
      slot1_instr <= '0;
      slot1_pc    <= '0;
    end else if (!redirect_valid) begin
      if (pop && (count == 2'd2)) begin
        slot0_instr <= slot1_instr;
        slot0_pc    <= slot1_pc;
      end
      if (push) begin
        if ((count == 2'd0) || (pop && (count == 2'd1))) begin
          slot0_instr <= imem_data_out;
          slot0_pc    <= pc;
        end else begin
          slot1_instr <= imem_data_out;
          slot1_pc    <= pc;
        end
      end
    end
  end
`else
  // This block updates the single output register.
  // A push only happens when the register is empty or is being popped, so the new word always replaces the head.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot0_instr <= NOP_INSTR;
      slot0_pc    <= '0;
    end else if (!redirect_valid && push) begin
      slot0_instr <= imem_data_out;
      slot0_pc    <= pc;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit
//   Directed and randomized stimulus for imem_fetch_unit. The bench checks the
//   DUT against a queue-based reference model of the fetch buffer. The bench
//   also contains a behavioural imem that returns a word computed from the address.

module tb_imem_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h01000000;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
`ifdef FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;

  int vectors     = 0;
  int miscompares = 0;
  int checks      = 0;

  // These variables form the reference model: the PC, the fault record, the
  // FIFO contents and the values currently shown on the outputs.
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_fault_pc;
  logic [31:0] m_show_instr;
  logic [31:0] m_show_pc;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];

  // The clock toggles every 5 time units.
  always #5 clock = ~clock;

  // The behavioural instruction memory returns a distinct word for each address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C0F13;
  endfunction

  assign imem_data_out = mem_word(imem_address);

  imem_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .fault           (fault),
    .fault_pc        (fault_pc),
    .imem_address    (imem_address),
    .imem_read_write (imem_read_write),
    .imem_data_in    (imem_data_in),
    .imem_data_out   (imem_data_out)
  );

  task automatic applyStimulus(input logic r, input logic fe, input logic rv,
                               input logic [31:0] tgt, input logic rdy);
    reset           = r;
    fetch_en        = fe;
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h (vector %0d)", tag, obs, exp, vectors);
    end
  endtask

  // The model advances one clock edge using the inputs that are present at the edge.
  task automatic modelEdge();
    bit do_pop;
    bit do_push;
    bit has_room;
    if (reset) begin
      m_pc         = RESET_PC;
      m_fault      = 1'b0;
      m_fault_pc   = 32'h0;
      m_show_instr = NOP_INSTR;
      m_show_pc    = 32'h0;
      q_instr.delete();
      q_pc.delete();
    end else if (redirect_valid) begin
      q_instr.delete();
      q_pc.delete();
      if (redirect_target[1:0] == 2'b00) begin
        m_pc    = redirect_target;
        m_fault = 1'b0;
      end else begin
        m_fault    = 1'b1;
        m_fault_pc = redirect_target;
      end
    end else begin
      do_pop   = (q_pc.size() > 0) && out_ready;
      has_room = (q_pc.size() < DEPTH) || do_pop;
      do_push  = !m_fault && fetch_en && has_room;
      if (do_pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (do_push) begin
        q_instr.push_back(mem_word(m_pc));
        q_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    if (q_pc.size() > 0) begin
      m_show_instr = q_instr[0];
      m_show_pc    = q_pc[0];
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, (q_pc.size() > 0)});
    checkOutput("out_instr", out_instr, m_show_instr);
    checkOutput("out_pc", out_pc, m_show_pc);
    checkOutput("fault", {31'b0, fault}, {31'b0, m_fault});
    checkOutput("fault_pc", fault_pc, m_fault_pc);
    checkOutput("imem_address", imem_address, m_pc);
    checkOutput("imem_read_write", {31'b0, imem_read_write}, 32'h0);
    checkOutput("imem_data_in", imem_data_in, 32'h0);
  endtask

  // Each step waits for one clock edge, advances the model and samples the DUT 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    modelEdge();
    vectors++;
    #1;
    checkAll();
  endtask

  initial begin
    logic [31:0] tgt;
    int          r;

    // Reset, then stream with decode always ready.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_out_instr", out_instr, NOP_INSTR);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t1_pc0", out_pc, 32'h01000000);
    step();
    checkOutput("t1_pc1", out_pc, 32'h01000004);
    step();
    checkOutput("t1_pc2", out_pc, 32'h01000008);

    // Decode stalls for three cycles in the middle of the stream, then drains.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (4) step();

    // A redirect while a pop is in progress: the pop is discarded and the target follows.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h01000040, 1'b1);
    step();
    checkOutput("t3_flush_valid", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t3_target_pc", out_pc, 32'h01000040);
    step();

    // A misaligned target faults. A later aligned redirect recovers.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h01000042, 1'b1);
    step();
    checkOutput("t4_fault", {31'b0, fault}, 32'h1);
    checkOutput("t4_fault_pc", fault_pc, 32'h01000042);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2) step();
    checkOutput("t4_halted_valid", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h01000010, 1'b1);
    step();
    checkOutput("t4_fault_clear", {31'b0, fault}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t4_recover_pc", out_pc, 32'h01000010);

    // The PC wraps around the top of the address space.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkOutput("t5_top_pc", out_pc, 32'hFFFFFFFC);
    step();
    checkOutput("t5_wrap_pc", out_pc, 32'h00000000);
    checkOutput("t5_no_fault", {31'b0, fault}, 32'h0);

    // Reset is asserted while the buffer is full and decode is stalled.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    checkOutput("t6_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("t6_pc", imem_address, RESET_PC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();

    // Randomized traffic with occasional redirects, faults, wrap targets and resets.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      tgt = 32'h0;
      if (r < 9) begin
        case ($urandom_range(0, 7))
          0, 1:    tgt = RESET_PC + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(1, 3));
          2:       tgt = 32'hFFFFFFF8 + 32'($urandom_range(0, 1) * 4);
          default: tgt = RESET_PC + 32'($urandom_range(0, 255) * 4);
        endcase
      end
      applyStimulus((r == 99), ($urandom_range(0, 9) != 0), (r < 9), tgt,
                    ($urandom_range(0, 3) != 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
